// File: rtl/ddr_local_responder.sv
`default_nettype none
// ==========================================================================
// ddr_local_responder - DDR controller local-interface responder on on-chip RAM
// Rev 1.0
// ==========================================================================
module ddr_local_responder #(
  parameter int ADDR_W         = 23,
  parameter int DATA_W         = 32,
  parameter int MEM_AW         = 10,
  parameter int INIT_CYCLES    = 64,
  parameter int RD_LATENCY     = 4,
  parameter int REFRESH_PERIOD = 0,
  parameter int REFRESH_CYCLES = 8
) (
  input  logic                phy_clk,
  input  logic                wb_rst_i,
  input  logic [ADDR_W-1:0]   local_address,
  input  logic                local_write_req,
  input  logic                local_read_req,
  input  logic                local_burstbegin,
  input  logic [DATA_W-1:0]   local_wdata,
  input  logic [DATA_W/8-1:0] local_be,
  input  logic [1:0]          local_size,
  output logic                local_ready,
  output logic [DATA_W-1:0]   local_rdata,
  output logic                local_rdata_valid,
  output logic                local_init_done,
  output logic                local_refresh_ack,
  output logic                local_wdata_req,
  output logic                proto_err_o
);

  localparam int BE_W   = DATA_W / 8;
  localparam int PIPE_D = RD_LATENCY - 1;
  localparam int RT_W   = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam logic [15:0]     INIT_LAST = 16'(INIT_CYCLES - 1);
  localparam logic [RT_W-1:0] RT_LAST   = RT_W'((REFRESH_PERIOD > 0) ? REFRESH_PERIOD - 1 : 0);
  localparam logic [7:0]      RC_LAST   = 8'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_REFRESH = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [15:0]     init_cnt, init_cnt_nxt;
  logic [RT_W-1:0] rtimer, rtimer_nxt;
  logic [7:0]      rcnt, rcnt_nxt;
  logic            ready_nxt, ack_nxt;

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    rtimer_nxt   = rtimer;
    rcnt_nxt     = rcnt;
    case (state)
      ST_INIT: begin
        if (init_cnt == INIT_LAST) state_nxt = ST_IDLE;
        else                       init_cnt_nxt = init_cnt + 16'd1;
      end
      ST_IDLE: begin
        if (REFRESH_PERIOD != 0) begin
          if (rtimer == RT_LAST) begin
            state_nxt  = ST_REFRESH;
            rtimer_nxt = '0;
            rcnt_nxt   = '0;
          end else begin
            rtimer_nxt = rtimer + RT_W'(1);
          end
        end
      end
      ST_REFRESH: begin
        if (rcnt == RC_LAST) state_nxt = ST_IDLE;
        else                 rcnt_nxt  = rcnt + 8'd1;
      end
      default: state_nxt = ST_INIT;
    endcase
    // Ready and ack are registered copies of the upcoming state.
    ready_nxt = (state_nxt == ST_IDLE);
    ack_nxt   = (state_nxt == ST_REFRESH) && (rcnt_nxt == RC_LAST);
  end

  always_ff @(posedge phy_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state             <= ST_INIT;
      init_cnt          <= '0;
      rtimer            <= '0;
      rcnt              <= '0;
      local_ready       <= 1'b0;
      local_refresh_ack <= 1'b0;
      local_init_done   <= 1'b0;
    end else begin
      state             <= state_nxt;
      init_cnt          <= init_cnt_nxt;
      rtimer            <= rtimer_nxt;
      rcnt              <= rcnt_nxt;
      local_ready       <= ready_nxt;
      local_refresh_ack <= ack_nxt;
      local_init_done   <= local_init_done | ready_nxt;
    end
  end

  logic              any_req, accept, wr_acc, rd_acc, err_set;
  logic [MEM_AW-1:0] mem_addr;

  assign any_req  = local_read_req | local_write_req;
  assign accept   = local_ready & any_req;
  assign wr_acc   = accept & local_write_req;
  assign rd_acc   = accept & local_read_req & ~local_write_req;
  assign mem_addr = local_address[MEM_AW-1:0];
  assign err_set  = (accept & local_read_req & local_write_req)
                  | (accept & (local_size != 2'd1))
                  | (any_req & ~local_init_done);

  assign local_wdata_req = wr_acc;

  logic unused_inputs;
  assign unused_inputs = ^{local_burstbegin, local_address};

  always_ff @(posedge phy_clk or posedge wb_rst_i) begin
    if (wb_rst_i)     proto_err_o <= 1'b0;
    else if (err_set) proto_err_o <= 1'b1;
  end

  logic [DATA_W-1:0] mem [2**MEM_AW];

  always_ff @(posedge phy_clk) begin
    if (wr_acc) begin
      for (int i = 0; i < BE_W; i++) begin
        if (local_be[i]) mem[mem_addr][i*8 +: 8] <= local_wdata[i*8 +: 8];
      end
    end
  end

  // Data stages carry no reset; only the valid bits need flushing.
  logic [PIPE_D-1:0] pipe_v;
  logic [DATA_W-1:0] pipe_d [PIPE_D];

  always_ff @(posedge phy_clk) begin
    pipe_d[0] <= mem[mem_addr];
    for (int i = 1; i < PIPE_D; i++) pipe_d[i] <= pipe_d[i-1];
  end

  always_ff @(posedge phy_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pipe_v            <= '0;
      local_rdata_valid <= 1'b0;
      local_rdata       <= '0;
    end else begin
      pipe_v[0] <= rd_acc;
      for (int i = 1; i < PIPE_D; i++) pipe_v[i] <= pipe_v[i-1];
      local_rdata_valid <= pipe_v[PIPE_D-1];
      if (pipe_v[PIPE_D-1]) local_rdata <= pipe_d[PIPE_D-1];
    end
  end

endmodule
`default_nettype wire
